turn_signal_ctrl: RTL and testbench

Turn-signal request controller for the car's lamp subsystem. Converts the raw left, right and hazard push-buttons into clean per-side direction levels plus a restart pulse. These outputs feed the per-side lamp flasher blocks, which only blink the lamp. The block synchronises and debounces the buttons, runs the IDLE/LEFT/RIGHT/HAZARD state machine, gates it by the car operating mode, and auto-cancels a turn signal after a fixed time.

---
 rtl/turn_signal_ctrl.sv | 153 +++++++++++++++
 tb/tb_turn_signal_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_ctrl.sv
// Turn-signal request controller: conditions the left/right/hazard buttons and
// runs the IDLE/LEFT/RIGHT/HAZARD request FSM with mode gating and auto-cancel.

module turn_signal_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d, level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press = level_q & ~level_dly_q;
endmodule

module turn_signal_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int AUTO_CANCEL_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_hazard,
  output logic       dir_left,
  output logic       dir_right,
  output logic       restart,
  output logic [1:0] sig_state
);
  localparam int NUM_BTN = 3;
  localparam int AW      = (AUTO_CANCEL_CYCLES > 1) ? $clog2(AUTO_CANCEL_CYCLES) : 1;
  localparam logic [AW-1:0] AC_LAST = AW'(AUTO_CANCEL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEFT   = 2'd1,
    S_RIGHT  = 2'd2,
    S_HAZARD = 2'd3
  } sig_state_e;

  logic [NUM_BTN-1:0] btn_raw, press;
  sig_state_e         state_q, state_d;
  logic [AW-1:0]      ac_cnt_q, ac_cnt_d;
  logic               restart_q, restart_d;
  logic               en, p_left, p_right, p_haz, ac_done;

  assign btn_raw = {btn_hazard, btn_right, btn_left};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    turn_signal_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .press   (press[i])
    );
  end

  assign en = (state == 3'd3) || (state == 3'd4);

  // Simultaneous left+right presses cancel; hazard always wins.
  assign p_haz   = press[2];
  assign p_left  = press[0] & ~press[1];
  assign p_right = press[1] & ~press[0];
  assign ac_done = (ac_cnt_q == AC_LAST);

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if      (p_haz)   state_d = S_HAZARD;
          else if (p_left)  state_d = S_LEFT;
          else if (p_right) state_d = S_RIGHT;
        end
        S_LEFT: begin
          if      (p_haz)   state_d = S_HAZARD;
          else if (p_left)  state_d = S_IDLE;
          else if (p_right) state_d = S_RIGHT;
          else if (ac_done) state_d = S_IDLE;
        end
        S_RIGHT: begin
          if      (p_haz)   state_d = S_HAZARD;
          else if (p_right) state_d = S_IDLE;
          else if (p_left)  state_d = S_LEFT;
          else if (ac_done) state_d = S_IDLE;
        end
        S_HAZARD: begin
          if (p_haz) state_d = S_IDLE;
        end
      endcase
    end
  end

  // Auto-cancel timer measures dwell time in the current LEFT/RIGHT state only.
  always_comb begin
    ac_cnt_d  = '0;
    if ((state_d == state_q) && ((state_q == S_LEFT) || (state_q == S_RIGHT)))
      ac_cnt_d = ac_cnt_q + 1'b1;
    restart_d = (state_d != state_q) && (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ac_cnt_q  <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ac_cnt_q  <= ac_cnt_d;
      restart_q <= restart_d;
    end
  end

  assign dir_left  = (state_q == S_LEFT)  || (state_q == S_HAZARD);
  assign dir_right = (state_q == S_RIGHT) || (state_q == S_HAZARD);
  assign restart   = restart_q;
  assign sig_state = state_q;
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Scoreboard bench for turn_signal_ctrl: directed scenarios followed by random
// button/mode/reset traffic, checked against a timestamp-based reference model.

module tb_turn_signal_ctrl;
  localparam int D  = 4;
  localparam int AC = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state = 3'd3;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_hazard = 1'b0;
  logic       dir_left, dir_right, restart;
  logic [1:0] sig_state;

  always #5 clk = ~clk;

  turn_signal_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_CANCEL_CYCLES(AC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_hazard (btn_hazard),
    .dir_left   (dir_left),
    .dir_right  (dir_right),
    .restart    (restart),
    .sig_state  (sig_state)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] exp_q[$];

  // Reference model: raw samples kept per edge; a button level is accepted once
  // D consecutive synchronised samples (raw delayed by two edges) disagree with it.
  bit [2:0] hist[$];
  int       t = 0;
  int       last_rst = -1;
  bit [2:0] deb = '0, deb_prev = '0;
  int       st = 0;
  int       entry = 0;
  bit       rs = 1'b0;

  function automatic bit smp(input int k, input int b);
    if (k < 0 || k <= last_rst) return 1'b0;
    return hist[k][b];
  endfunction

  task automatic model_edge(input bit l, input bit r, input bit h, input logic [2:0] m, input bit rn);
    bit [2:0] ev, nd;
    bit       pl, pr, ph, en, acd, flip;
    int       nx;
    if (!rn) begin
      last_rst = t;
      deb = '0; deb_prev = '0; st = 0; rs = 1'b0; entry = t;
    end else begin
      ev  = deb & ~deb_prev;
      pl  = ev[0] && !ev[1];
      pr  = ev[1] && !ev[0];
      ph  = ev[2];
      en  = (m == 3'd3) || (m == 3'd4);
      acd = (st == 1 || st == 2) && (t - entry == AC);
      nx  = st;
      if (!en)            nx = 0;
      else if (st == 3) begin
        if (ph) nx = 0;
      end
      else if (ph)        nx = 3;
      else if (pl)        nx = (st == 1) ? 0 : 1;
      else if (pr)        nx = (st == 2) ? 0 : 2;
      else if (acd)       nx = 0;
      rs = (nx != st) && (nx != 0);
      if (nx != st) entry = t;
      st = nx;
      for (int b = 0; b < 3; b++) begin
        flip = 1'b1;
        for (int k = t - D - 1; k <= t - 2; k++)
          if (smp(k, b) == deb[b]) flip = 1'b0;
        nd[b] = deb[b] ^ flip;
      end
      deb_prev = deb;
      deb      = nd;
    end
    hist.push_back({h, r, l});
    t++;
  endtask

  task automatic step(input bit l, input bit r, input bit h, input logic [2:0] m, input bit rn);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_hazard = h; state = m; rst_n = rn;
    model_edge(l, r, h, m, rn);
    exp_q.push_back({(st == 1 || st == 3), (st == 2 || st == 3), rs, 2'(st)});
  endtask

  task automatic press(input bit l, input bit r, input bit h, input logic [2:0] m, input int hold);
    repeat (hold) step(l, r, h, m, 1'b1);
    repeat (8)    step(1'b0, 1'b0, 1'b0, m, 1'b1);
  endtask

  // Monitor: one comparison per clock edge against the queued expectation.
  int mon_edge = 0;
  initial begin
    logic [4:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {dir_left, dir_right, restart, sig_state};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs edge %0d: got {dl,dr,rst,st}=%b required %b", mon_edge, got, e);
        end
        mon_edge++;
      end
    end
  end

  logic [2:0] off_modes [6] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};

  initial begin
    int         hold [3];
    bit         lv   [3];
    int         mhold, sel;
    logic [2:0] mode;

    repeat (3) step(0, 0, 0, 3'd3, 1'b0);
    // held left: enter LEFT, auto-cancel after AC cycles
    repeat (40) step(1, 0, 0, 3'd3, 1'b1);
    repeat (8)  step(0, 0, 0, 3'd3, 1'b1);
    // toggle off, then right -> left switch
    press(1, 0, 0, 3'd3, 6); press(1, 0, 0, 3'd3, 6);
    press(0, 1, 0, 3'd3, 6); press(1, 0, 0, 3'd3, 6);
    // hazard over LEFT, left presses ignored, hazard off
    press(0, 0, 1, 3'd3, 6);
    repeat (3) press(1, 0, 0, 3'd3, 6);
    press(0, 0, 1, 3'd3, 6);
    // glitch, simultaneous left+right, simultaneous left+hazard
    press(0, 1, 0, 3'd3, 3);
    press(1, 1, 0, 3'd3, 6);
    press(1, 0, 1, 3'd3, 6);
    press(0, 0, 1, 3'd3, 6);
    // mode gating
    press(1, 0, 0, 3'd3, 6);
    repeat (3) step(0, 0, 0, 3'd1, 1'b1);
    press(0, 1, 0, 3'd1, 6);
    press(0, 1, 0, 3'd4, 6);
    // reset in HAZARD with left held through it
    press(0, 0, 1, 3'd3, 6);
    repeat (5) step(1, 0, 0, 3'd3, 1'b1);
    step(1, 0, 0, 3'd3, 1'b0);
    repeat (30) step(1, 0, 0, 3'd3, 1'b1);
    repeat (8)  step(0, 0, 0, 3'd3, 1'b1);

    for (int b = 0; b < 3; b++) begin hold[b] = 0; lv[b] = 1'b0; end
    mhold = 0; mode = 3'd3;
    for (int i = 0; i < 15000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lv[b] = ~lv[b];
          sel   = int'($urandom_range(0, 9));
          if (sel < 2)      hold[b] = int'($urandom_range(1, 3));
          else if (sel < 8) hold[b] = int'($urandom_range(5, 25));
          else              hold[b] = int'($urandom_range(26, 60));
        end
        hold[b]--;
      end
      if (mhold == 0) begin
        if ($urandom_range(0, 7) < 6) mode = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd3;
        else                          mode = off_modes[$urandom_range(0, 5)];
        mhold = int'($urandom_range(10, 200));
      end
      mhold--;
      step(lv[0], lv[1], lv[2], mode, ($urandom_range(0, 999) != 0));
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
